// File: rtl/prim_rst_seq.sv
// Reset release sequencer: releases NUM_STAGES active-low domain resets one at a time and replays the sequence on a soft-reset request.
// Optional macro RST_SEQ_REVERSE_ASSERT_EN: soft reset asserts stages from highest to lowest, STAGE_DLY apart.
module prim_rst_seq #(
    parameter int NUM_STAGES = 3,
    parameter int HOLD_CYC   = 8,
    parameter int STAGE_DLY  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  soft_rst_req_i,
    output logic                  soft_rst_ack_o,
    output logic [NUM_STAGES-1:0] rst_stage_no,
    output logic                  all_rdy_o
);

    localparam int CNT_MAX = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] DLY_END  = CNT_W'(STAGE_DLY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN, SOFT} state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_STAGES-1:0]   stage_q;
    logic                    req_q;
    logic                    soft_q;
    logic                    ack_q;
    logic                    rdy_q;

    logic                    req_rise;
    logic [NUM_STAGES-1:0]   stage_rel;
    logic [NUM_STAGES-1:0]   stage_drop;
    logic [CNT_W-1:0]        cnt_end;

    assign req_rise   = soft_rst_req_i & ~req_q;
    // Released stages are always a contiguous run of ones from bit 0, so
    // releasing the next stage is a shift-in of a one and dropping the top
    // released stage is a right shift.
    assign stage_rel  = (stage_q << 1) | NUM_STAGES'(1);
    assign stage_drop = stage_q >> 1;
    assign cnt_end    = (state_q == HOLD) ? HOLD_END : DLY_END;

    // The counter holds cycles elapsed since the last stage boundary; a
    // boundary edge itself counts as the first cycle of the next interval.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            req_q   <= 1'b0;
            soft_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            req_q <= soft_rst_req_i;
            ack_q <= 1'b0;
            case (state_q)
                HOLD, RELEASE: begin
                    if (cnt_q == cnt_end) begin
                        stage_q <= stage_rel;
                        cnt_q   <= CNT_ONE;
                        if (&stage_rel) begin
                            state_q <= RUN;
                            rdy_q   <= 1'b1;
                            ack_q   <= soft_q;
                            soft_q  <= 1'b0;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (req_rise) begin
                        state_q <= SOFT;
                        soft_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                SOFT: begin
`ifdef RST_SEQ_REVERSE_ASSERT_EN
                    // rdy_q still high means nothing has dropped yet.
                    if (rdy_q || (cnt_q == DLY_END)) begin
                        stage_q <= stage_drop;
                        rdy_q   <= 1'b0;
                        cnt_q   <= CNT_ONE;
                        if (stage_drop == '0) begin
                            state_q <= HOLD;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
`else
                    stage_q <= '0;
                    rdy_q   <= 1'b0;
                    cnt_q   <= CNT_ONE;
                    state_q <= HOLD;
`endif
                end
                default: begin
                    state_q <= HOLD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rst_stage_no   = stage_q;
    assign all_rdy_o      = rdy_q;
    assign soft_rst_ack_o = ack_q;

endmodule

// File: tb/tb_prim_rst_seq.sv
// Bench for prim_rst_seq: timeline model of release/drop times plus directed literal checkpoints.
module tb_prim_rst_seq;

`ifdef RST_SEQ_REVERSE_ASSERT_EN
    localparam int REV    = 1;
    localparam int H      = 2;
    localparam int D      = 4;
    localparam int DROP_T = 3;
    localparam int MID_T  = 7;
`else
    localparam int REV    = 0;
    localparam int H      = 8;
    localparam int D      = 16;
    localparam int DROP_T = 20;
    localparam int MID_T  = 30;
`endif
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic         ack;
    logic [N-1:0] stage;
    logic         rdy;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    int cyc = 0;

    int  o = 0;
    int  soft_s = -1;
    int  cnt_m = 0;
    bit  running = 1'b0;
    bit  flag = 1'b0;
    bit  req_prev = 1'b0;
    logic [N-1:0] exp_stage;
    logic         exp_rdy;
    logic         exp_ack;

    prim_rst_seq #(.NUM_STAGES(N), .HOLD_CYC(H), .STAGE_DLY(D)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .soft_rst_req_i (req),
        .soft_rst_ack_o (ack),
        .rst_stage_no   (stage),
        .all_rdy_o      (rdy)
    );

    always #5 clk = ~clk;

    function automatic int released(input int t);
        int c;
        c = 0;
        for (int k = 0; k < N; k++)
            if (t >= H + k * D) c++;
        return c;
    endfunction

    always @(posedge clk) begin : model
        bit prev_run;
        int c;
        cyc++;
        exp_ack = 1'b0;
        c = 0;
        if (!rst_n) begin
            running  = 1'b0;
            flag     = 1'b0;
            soft_s   = -1;
            req_prev = 1'b0;
        end else begin
            prev_run = (cnt_m == N) && (soft_s < 0);
            if (!running) begin
                running = 1'b1;
                o = cyc;
            end
            if (req && !req_prev && prev_run) begin
                soft_s = cyc;
                flag   = 1'b1;
                o      = cyc + 1 + REV * (N - 1) * D;
            end
            if (soft_s >= 0 && cyc == soft_s) begin
                c = N;
            end else if (soft_s >= 0 && cyc < o) begin
                c = N - 1 - (cyc - soft_s - 1) / D;
            end else begin
                c = released(cyc - o);
                if (c == N && (cyc - o) == H + (N - 1) * D) begin
                    exp_ack = flag;
                    flag    = 1'b0;
                    soft_s  = -1;
                end
            end
            req_prev = req;
        end
        cnt_m     = c;
        exp_stage = N'((1 << c) - 1);
        exp_rdy   = (c == N);
        #1;
        checks++;
        if (stage !== exp_stage || rdy !== exp_rdy || ack !== exp_ack) begin
            errors++;
            $display("FAIL model cyc=%0d got stage=%b rdy=%b ack=%b expected stage=%b rdy=%b ack=%b",
                     cyc, stage, rdy, ack, exp_stage, exp_rdy, exp_ack);
        end
        if (ack === 1'b1) ack_cnt++;
    end

    task automatic chk(input string name, input logic [N-1:0] st, input logic rd);
        checks++;
        if (stage !== st || rdy !== rd) begin
            errors++;
            $display("FAIL %s got stage=%b rdy=%b expected stage=%b rdy=%b", name, stage, rdy, st, rd);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // power-on sequence
        cycles(5);
        chk("in_reset", '0, 1'b0);
        rst_n = 1'b1;
        cycles(H);
        chk("hold", 3'b000, 1'b0);
        cycles(1);
        chk("stage0", 3'b001, 1'b0);
        cycles(D - 1);
        chk("pre_stage1", 3'b001, 1'b0);
        cycles(1);
        chk("stage1", 3'b011, 1'b0);
        cycles(D);
        chk("stage2", 3'b111, 1'b1);
        cycles(10);
        chk_int("no_poweron_ack", ack_cnt, 0);

        // soft reset, request held through the ack
        req = 1'b1;
        cycles(1);
        chk("soft_entry", 3'b111, 1'b1);
        cycles(1);
        chk("soft_first", (REV != 0) ? 3'b011 : 3'b000, 1'b0);
        cycles(100);
        chk_int("one_ack_held", ack_cnt, 1);
        chk("after_soft", 3'b111, 1'b1);

        // drop for one cycle, raise again
        req = 1'b0;
        cycles(1);
        req = 1'b1;
        cycles(100);
        chk_int("second_ack", ack_cnt, 2);
        req = 1'b0;

        // rising edge during RELEASE is dropped
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(DROP_T);
        req = 1'b1;
        cycles(3);
        req = 1'b0;
        cycles(60);
        chk_int("dropped_req_no_ack", ack_cnt, 2);
        chk("dropped_req_run", 3'b111, 1'b1);

        // reset mid-RELEASE
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(MID_T);
        rst_n = 1'b0;
        cycles(1);
        chk("rst_mid_release", 3'b000, 1'b0);
        rst_n = 1'b1;
        cycles(H);
        chk("retime_hold", 3'b000, 1'b0);
        cycles(1);
        chk("retime_stage0", 3'b001, 1'b0);
        cycles(60);
        chk_int("no_ack_after_rst", ack_cnt, 2);

        // reset mid-soft sequence
        req = 1'b1;
        cycles(1);
        req = 1'b0;
        cycles(5);
        rst_n = 1'b0;
        cycles(1);
        chk("rst_mid_soft", 3'b000, 1'b0);
        rst_n = 1'b1;
        cycles(80);
        chk_int("no_ack_after_soft_rst", ack_cnt, 2);
        chk("final_run", 3'b111, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
